// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: FSM state encoding, instruction
// width, PC increment and the default halt instruction word.
package fetch_stage_pkg;

  localparam int unsigned InstWidth = 32;
  localparam logic [InstWidth-1:0] PcIncr = 32'd4;
  localparam logic [InstWidth-1:0] DefaultHaltWord = 32'h0000_0073;
  localparam int unsigned CntWidth = 4;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StHalted = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_halt_ctl.sv
// Fetch halt controller: owns the RUN/DRAIN/HALTED state, the drain counter and the
// sticky halt register.
//   clk, rst            : clock, asynchronous active-high reset
//   stall_i             : hazard hold; freezes the drain countdown
//   redirect_i          : redirect taken; aborts a drain (wrong-path halt word)
//   halt_hit_i          : unstalled, unredirected capture of the halt word in RUN
//   state_o             : current FSM state, used by the PC / IF-ID datapath
//   halt_o              : registered halt flag, sticky until reset
module fetch_halt_ctl
  import fetch_stage_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_i,
  input  logic         redirect_i,
  input  logic         halt_hit_i,
  output fetch_state_e state_o,
  output logic         halt_o
);

  localparam logic [CntWidth-1:0] CntInit = CntWidth'(DRAIN_CYCLES - 1);

  fetch_state_e        state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                halt_q, halt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (halt_hit_i) begin
          state_d = StDrain;
          cnt_d   = CntInit;
        end
      end
      StDrain: begin
        if (redirect_i) begin
          state_d = StRun;
          cnt_d   = '0;
        end else if (!stall_i) begin
          if (cnt_q == '0) state_d = StHalted;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      StHalted: ;
      default: begin
        state_d = StRun;
        cnt_d   = '0;
      end
    endcase
    // Halt is registered alongside the state so it has no combinational input path.
    halt_d = (state_d == StHalted);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
    end
  end

  assign state_o = state_q;
  assign halt_o  = halt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and halt handling.
//   clk, rst        : clock, asynchronous active-high reset
//   imem_addr       : instruction memory byte address (always equals PC)
//   imem_rdata      : combinational instruction word at imem_addr
//   stall           : hazard hold request
//   redirect_valid  : branch/jump taken; redirect_pc gives the target (word-aligned here)
//   if_valid/if_pc/if_inst : IF/ID register contents
//   halt            : program complete, sticky until reset
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD    = DefaultHaltWord,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [InstWidth-1:0] imem_addr,
  input  logic [InstWidth-1:0] imem_rdata,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [InstWidth-1:0] redirect_pc,
  output logic                 if_valid,
  output logic [InstWidth-1:0] if_pc,
  output logic [InstWidth-1:0] if_inst,
  output logic                 halt
);

  fetch_state_e         state;
  logic [InstWidth-1:0] pc_q, pc_d;
  logic                 valid_q, valid_d;
  logic [InstWidth-1:0] if_pc_q, if_pc_d;
  logic [InstWidth-1:0] if_inst_q, if_inst_d;
  logic                 halt_hit;

  assign halt_hit = (state == StRun) && !redirect_valid && !stall && (imem_rdata == HALT_WORD);

  fetch_halt_ctl #(
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) u_halt_ctl (
    .clk       (clk),
    .rst       (rst),
    .stall_i   (stall),
    .redirect_i(redirect_valid),
    .halt_hit_i(halt_hit),
    .state_o   (state),
    .halt_o    (halt)
  );

  always_comb begin
    pc_d      = pc_q;
    valid_d   = valid_q;
    if_pc_d   = if_pc_q;
    if_inst_d = if_inst_q;
    unique case (state)
      StRun: begin
        if (redirect_valid) begin
          pc_d    = {redirect_pc[31:2], 2'b00};
          valid_d = 1'b0;
        end else if (!stall) begin
          valid_d   = 1'b1;
          if_pc_d   = pc_q;
          if_inst_d = imem_rdata;
          // The halt word is captured but the PC parks on it.
          if (!halt_hit) pc_d = pc_q + PcIncr;
        end
      end
      StDrain: begin
        if (redirect_valid) begin
          pc_d    = {redirect_pc[31:2], 2'b00};
          valid_d = 1'b0;
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end
      StHalted: valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
      if_pc_q   <= '0;
      if_inst_q <= '0;
    end else begin
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      if_pc_q   <= if_pc_d;
      if_inst_q <= if_inst_d;
    end
  end

  assign imem_addr = pc_q;
  assign if_valid  = valid_q;
  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small combinational instruction memory.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        halt;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  // Program: two addi's, then the halt word; everything else reads as a nop.
  always_comb begin
    unique case (imem_addr)
      32'h0:   imem_rdata = 32'h0010_0093;
      32'h4:   imem_rdata = 32'h0020_0113;
      32'h8:   imem_rdata = 32'h0000_0073;
      default: imem_rdata = 32'h0000_0013;
    endcase
  end

  fetch_stage #(
    .RESET_PC    (32'h0000_0000),
    .HALT_WORD   (32'h0000_0073),
    .DRAIN_CYCLES(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .halt          (halt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #2;
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_inst", if_inst, 32'h0);
    check("rst_halt", {31'd0, halt}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Straight-line fetch
    step();
    check("f0_pc", if_pc, 32'h0);
    check("f0_inst", if_inst, 32'h0010_0093);
    check("f0_valid", {31'd0, if_valid}, 32'd1);
    check("f0_addr", imem_addr, 32'h4);
    step();
    check("f1_pc", if_pc, 32'h4);
    check("f1_addr", imem_addr, 32'h8);

    // Stall at PC=8 for three cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stl_addr", imem_addr, 32'h8);
      check("stl_pc", if_pc, 32'h4);
      check("stl_inst", if_inst, 32'h0020_0113);
      check("stl_valid", {31'd0, if_valid}, 32'd1);
    end
    stall = 1'b0;

    // Halt word capture, then four unstalled drain cycles
    step();
    check("hc_pc", if_pc, 32'h8);
    check("hc_inst", if_inst, 32'h0000_0073);
    check("hc_addr", imem_addr, 32'h8);
    check("hc_halt", {31'd0, halt}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("dr_halt", {31'd0, halt}, 32'd0);
      check("dr_valid", {31'd0, if_valid}, 32'd0);
    end
    step();
    check("halt_set", {31'd0, halt}, 32'd1);

    // Halted: redirect and stall ignored
    stall = 1'b1;
    redirect_to(32'h40);
    stall = 1'b0;
    check("hl_addr", imem_addr, 32'h8);
    check("hl_halt", {31'd0, halt}, 32'd1);
    check("hl_valid", {31'd0, if_valid}, 32'd0);

    // Reset out of HALTED, then redirect with simultaneous stall
    rst = 1'b1; #2;
    check("rh_halt", {31'd0, halt}, 32'd0);
    rst = 1'b0;
    step();
    check("rf_pc", if_pc, 32'h0);
    stall = 1'b1;
    redirect_to(32'h43);
    stall = 1'b0;
    check("rd_addr", imem_addr, 32'h40);
    check("rd_valid", {31'd0, if_valid}, 32'd0);
    step();
    check("rd_fpc", if_pc, 32'h40);
    check("rd_fvalid", {31'd0, if_valid}, 32'd1);

    // Wrong-path halt aborted by a redirect during DRAIN
    redirect_to(32'h8);
    step();
    check("wp_cap", if_inst, 32'h0000_0073);
    step();
    redirect_to(32'h100);
    check("wp_addr", imem_addr, 32'h100);
    check("wp_halt", {31'd0, halt}, 32'd0);
    step();
    check("wp_pc", if_pc, 32'h100);
    check("wp_next", imem_addr, 32'h104);
    for (int i = 0; i < 5; i++) step();
    check("wp_nohalt", {31'd0, halt}, 32'd0);

    // Reset mid-DRAIN (counter at 2), checked between clock edges
    redirect_to(32'h8);
    step();
    step();
    rst = 1'b1; #1;
    check("rm_addr", imem_addr, 32'h0);
    check("rm_valid", {31'd0, if_valid}, 32'd0);
    check("rm_halt", {31'd0, halt}, 32'd0);
    check("rm_pc", if_pc, 32'h0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("rm_nohalt", {31'd0, halt}, 32'd0);

    // PC wrap
    redirect_to(32'hFFFF_FFFC);
    step();
    check("wr_pc", if_pc, 32'hFFFF_FFFC);
    check("wr_addr", imem_addr, 32'h0);
    check("wr_valid", {31'd0, if_valid}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC loaded on reset.
REQ-002 SHALL have parameter HALT_WORD, default 32'h0000_0073, giving the instruction word that terminates fetch.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 4, giving the unstalled cycles from halt-word capture to halt assertion; legal range 1..15.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port imem_addr, output, 32 bits: instruction memory byte address.
REQ-007 SHALL have port imem_rdata, input, 32 bits: instruction word at imem_addr, combinational read.
REQ-008 SHALL have port stall, input, 1 bit: hazard-unit hold request.
REQ-009 SHALL have port redirect_valid, input, 1 bit: branch/jump taken, so fetch restarts.
REQ-010 SHALL have port redirect_pc, input, 32 bits: redirect target.
REQ-011 SHALL have port if_valid, output, 1 bit: IF/ID register holds a live instruction.
REQ-012 SHALL have port if_pc, output, 32 bits: PC of the IF/ID instruction.
REQ-013 SHALL have port if_inst, output, 32 bits: IF/ID instruction word.
REQ-014 SHALL have port halt, output, 1 bit: program complete; sticky until reset.

Function
REQ-015 SHALL drive imem_addr = PC combinationally; imem_addr SHALL equal PC in every cycle.
REQ-016 SHALL use FSM states RUN, DRAIN and HALTED.
REQ-017 In RUN, redirect_valid=1: PC <= {redirect_pc[31:2],2'b00}; if_valid <= 0. Redirect has priority over stall and over halt detection.
REQ-018 In RUN, stall=1 and redirect_valid=0: PC, if_valid, if_pc and if_inst SHALL hold.
REQ-019 In RUN, otherwise: PC <= PC+4 modulo 2^32; if_valid <= 1; if_pc <= PC; if_inst <= imem_rdata. Latency from PC to IF/ID output is 1 cycle.
REQ-020 In RUN, unstalled and unredirected with imem_rdata == HALT_WORD: capture per REQ-019 except PC holds; go to DRAIN; counter <= DRAIN_CYCLES-1.
REQ-021 In DRAIN, PC SHALL hold. On an unstalled cycle: if_valid <= 0; then if counter == 0, go to HALTED, else decrement counter. On a stalled cycle: IF/ID and counter hold.
REQ-022 In DRAIN, redirect_valid=1 (the halt word was on a wrong path) SHALL apply REQ-017, clear the counter and return to RUN.
REQ-023 In HALTED: halt = 1; PC and IF/ID frozen with if_valid = 0; stall and redirect ignored.
REQ-024 halt SHALL be 0 in RUN and DRAIN, and SHALL be a registered output (decoded from state, no combinational input path).
REQ-025 PC wrap from 32'hFFFF_FFFC SHALL yield 32'h0000_0000 without a flag.

Reset
REQ-026 rst=1 SHALL asynchronously set PC=RESET_PC, state=RUN, counter=0, if_valid=0, if_pc=0, if_inst=0 and halt=0, including mid-DRAIN and in HALTED.
REQ-027 After rst deasserts, the first rising edge SHALL fetch from RESET_PC.

Structure
REQ-028 The shared pipeline package SHALL hold the FSM state encoding, the default HALT_WORD, the instruction width (32) and the PC increment (4).
REQ-029 The DRAIN counter and halt register SHALL be one sub-module, fetch_halt_ctl; PC and IF/ID registers stay in fetch_stage.

Verification
REQ-030 Straight-line fetch: RESET_PC=0, IMEM words 0x00100093, 0x00200113, 0x00000073 -> if_pc 0,4,8 on successive cycles; halt=1 exactly 4 unstalled cycles after the 0x73 capture.
REQ-031 Stall: stall=1 for 3 cycles at PC=8 -> imem_addr stays 8, IF/ID unchanged; the fetch resumes with if_pc=8.
REQ-032 Redirect with simultaneous stall: redirect_valid=1, redirect_pc=0x43 -> next PC 0x40, if_valid=0, stall ignored.
REQ-033 Wrong-path halt: halt word captured, then redirect to 0x100 in DRAIN -> state RUN, PC 0x100, halt stays 0.
REQ-034 Reset mid-DRAIN: rst=1 with counter=2 -> PC=RESET_PC, if_valid=0, halt=0 immediately, without waiting for a clock edge.
REQ-035 Wrap: PC=0xFFFF_FFFC, unstalled -> next PC 0x0, if_pc=0xFFFF_FFFC.
